// File: rtl/mem_port_arbiter_if.sv
// Two-requester memory port bundle: request/grant/done per port plus the memory pins.
// The slave modport is the arbiter's view; the master modport is the requesters' and memory's view.
interface mem_port_arbiter_if #(
    parameter int AW = 6,
    parameter int DW = 16
);
    logic          req0, we0, gnt0, done0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] wd0, rdata0;
    logic          req1, we1, gnt1, done1;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wd1, rdata1;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wd, mem_rd;
    logic          mem_we;

    modport slave (
        input  req0, we0, addr0, wd0, req1, we1, addr1, wd1, mem_rd,
        output gnt0, done0, rdata0, gnt1, done1, rdata1, mem_addr, mem_wd, mem_we
    );

    modport master (
        output req0, we0, addr0, wd0, req1, we1, addr1, wd1, mem_rd,
        input  gnt0, done0, rdata0, gnt1, done1, rdata1, mem_addr, mem_wd, mem_we
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between the CPU path (port 0) and the loader (port 1).
// Optional macro ARB_PERF_CNT_EN adds saturating grant/conflict counters.
//
// state  | meaning
// IDLE   | arbitrate; may grant one request this cycle; done pulse of previous access shows here
// ACCESS | memory pins driven from the issue registers for exactly one cycle
module mem_port_arbiter #(
    parameter int AW         = 6,
    parameter int DW         = 16,
    parameter int RESET_PRIO = 0
) (
    input  logic                clk,
    input  logic                reset,
    mem_port_arbiter_if.slave   bus
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [15:0]         grant_cnt0,
    output logic [15:0]         grant_cnt1,
    output logic [15:0]         conflict_cnt
`endif
);
    typedef enum logic {IDLE, ACCESS} state_e;

    state_e        state_q, state_d;
    logic          prio_q, prio_d;
    logic          sel_q;
    logic          iss_we_q;
    logic [AW-1:0] iss_addr_q;
    logic [DW-1:0] iss_wd_q;
    logic          done0_q, done1_q;
    logic [DW-1:0] rdata0_q, rdata1_q;
    logic          winner, gnt0, gnt1;

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        winner  = prio_q;
        if (bus.req0 && !bus.req1)
            winner = 1'b0;
        else if (bus.req1 && !bus.req0)
            winner = 1'b1;
        case (state_q)
            IDLE: begin
                gnt0 = bus.req0 && !winner;
                gnt1 = bus.req1 && winner;
                if (gnt0 || gnt1) begin
                    state_d = ACCESS;
                    prio_d  = ~winner;
                end
            end
            ACCESS: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            prio_q     <= (RESET_PRIO != 0);
            sel_q      <= 1'b0;
            iss_we_q   <= 1'b0;
            iss_addr_q <= '0;
            iss_wd_q   <= '0;
            done0_q    <= 1'b0;
            done1_q    <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            if (gnt0 || gnt1) begin
                sel_q      <= gnt1;
                iss_we_q   <= gnt1 ? bus.we1   : bus.we0;
                iss_addr_q <= gnt1 ? bus.addr1 : bus.addr0;
                iss_wd_q   <= gnt1 ? bus.wd1   : bus.wd0;
            end
            done0_q <= (state_q == ACCESS) && !sel_q;
            done1_q <= (state_q == ACCESS) && sel_q;
            // Writes leave the port's last read data untouched.
            if (state_q == ACCESS && !iss_we_q) begin
                if (sel_q)
                    rdata1_q <= bus.mem_rd;
                else
                    rdata0_q <= bus.mem_rd;
            end
        end
    end

    assign bus.gnt0     = gnt0;
    assign bus.gnt1     = gnt1;
    assign bus.done0    = done0_q;
    assign bus.done1    = done1_q;
    assign bus.rdata0   = rdata0_q;
    assign bus.rdata1   = rdata1_q;
    assign bus.mem_addr = iss_addr_q;
    assign bus.mem_wd   = iss_wd_q;
    // Reset in the middle of an access must not let the write reach the array.
    assign bus.mem_we   = (state_q == ACCESS) && iss_we_q && !reset;

`ifdef ARB_PERF_CNT_EN
    logic [15:0] grant_cnt0_q, grant_cnt1_q, conflict_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            grant_cnt0_q   <= '0;
            grant_cnt1_q   <= '0;
            conflict_cnt_q <= '0;
        end else begin
            if (gnt0 && grant_cnt0_q != 16'hFFFF)
                grant_cnt0_q <= grant_cnt0_q + 16'd1;
            if (gnt1 && grant_cnt1_q != 16'hFFFF)
                grant_cnt1_q <= grant_cnt1_q + 16'd1;
            if (state_q == IDLE && bus.req0 && bus.req1 && conflict_cnt_q != 16'hFFFF)
                conflict_cnt_q <= conflict_cnt_q + 16'd1;
        end
    end

    assign grant_cnt0   = grant_cnt0_q;
    assign grant_cnt1   = grant_cnt1_q;
    assign conflict_cnt = conflict_cnt_q;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a transaction-level model of the shared memory predicts
// grants, memory pin activity and done/rdata; a separate monitor compares at every falling edge.
module tb_mem_port_arbiter;
    localparam int RESET_PRIO = 0;

    typedef struct {
        int          cyc;
        bit          g0, g1, we, rst_prev;
        logic [5:0]  addr;
        logic [15:0] wd;
    } cyc_rec_t;

    typedef struct {
        int          cyc;
        int          port;
        bit          rd;
        logic [15:0] data;
    } done_rec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_port_arbiter_if bus ();

`ifdef ARB_PERF_CNT_EN
    logic [15:0] grant_cnt0, grant_cnt1, conflict_cnt;
`endif

    mem_port_arbiter #(.AW(6), .DW(16), .RESET_PRIO(RESET_PRIO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef ARB_PERF_CNT_EN
        ,
        .grant_cnt0   (grant_cnt0),
        .grant_cnt1   (grant_cnt1),
        .conflict_cnt (conflict_cnt)
`endif
    );

    function automatic logic [15:0] init_val(int i);
        if (i == 2) return 16'h2880;
        return 16'(i * 37 + 256) ^ 16'h5A5A;
    endfunction

    // Memory array on the arbiter's pins (not reset).
    logic [15:0] tmem [64];
    logic        mem_loaded = 1'b0;
    assign bus.mem_rd = tmem[bus.mem_addr];
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 64; i++) tmem[i] <= init_val(i);
            mem_loaded <= 1'b1;
        end else if (bus.mem_we) begin
            tmem[bus.mem_addr] <= bus.mem_wd;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, exp);
        end
    endtask

    cyc_rec_t  cq[$];
    done_rec_t dq[$];

    // Requester drive state
    bit          p_rst;
    bit          p_req [2];
    logic        p_we  [2];
    logic [5:0]  p_addr[2];
    logic [15:0] p_wd  [2];

    // Reference model: memory contents, arbiter occupancy, which port is favoured next
    logic [15:0] m_mem [64];
    bit          m_busy, m_prio, m_rst_prev, m_iss_we;
    int          m_iss_port;
    logic [5:0]  m_iss_addr;
    logic [15:0] m_iss_wd;
    bit          m_granted [2];
    int          m_gc [2];
    int          m_cc;
    logic [1:0]  dut_g;

    task automatic new_req(int p);
        p_req[p]  = 1'b1;
        p_we[p]   = 1'($urandom_range(1));
        p_addr[p] = 6'($urandom_range(7));
        p_wd[p]   = 16'($urandom);
    endtask

    task automatic step();
        cyc_rec_t r;
        int w;
        bit want0, want1;
        @(posedge clk);
        #1;
        cyc++;
        reset     = p_rst;
        want0     = p_req[0] && !p_rst;
        want1     = p_req[1] && !p_rst;
        bus.req0  = want0;
        bus.we0   = p_we[0];
        bus.addr0 = p_addr[0];
        bus.wd0   = p_wd[0];
        bus.req1  = want1;
        bus.we1   = p_we[1];
        bus.addr1 = p_addr[1];
        bus.wd1   = p_wd[1];
        r.cyc = cyc; r.g0 = 0; r.g1 = 0; r.we = 0;
        r.addr = m_iss_addr; r.wd = m_iss_wd; r.rst_prev = m_rst_prev;
        m_granted[0] = 0;
        m_granted[1] = 0;
        if (m_busy) begin
            r.we = m_iss_we && !p_rst;
            if (!p_rst) begin
                if (m_iss_we) begin
                    m_mem[m_iss_addr] = m_iss_wd;
                    dq.push_back('{cyc: cyc + 1, port: m_iss_port, rd: 1'b0, data: 16'h0});
                end else begin
                    dq.push_back('{cyc: cyc + 1, port: m_iss_port, rd: 1'b1, data: m_mem[m_iss_addr]});
                end
            end
            m_busy = 0;
        end else begin
            if (want0 && want1 && m_cc < 16'hFFFF) m_cc++;
            w = -1;
            if (want0 && want1) w = int'(m_prio);
            else if (want0)     w = 0;
            else if (want1)     w = 1;
            if (w >= 0) begin
                if (w == 0) r.g0 = 1; else r.g1 = 1;
                m_granted[w] = 1;
                if (m_gc[w] < 16'hFFFF) m_gc[w]++;
                m_busy     = 1;
                m_prio     = (w == 0);
                m_iss_port = w;
                m_iss_we   = p_we[w];
                m_iss_addr = p_addr[w];
                m_iss_wd   = p_wd[w];
            end
        end
        if (p_rst) begin
            m_busy = 0; m_prio = (RESET_PRIO != 0);
            m_iss_we = 0; m_iss_addr = 0; m_iss_wd = 0; m_iss_port = 0;
            m_gc[0] = 0; m_gc[1] = 0; m_cc = 0;
        end
        m_rst_prev = p_rst;
        cq.push_back(r);
        #1;
        dut_g = {bus.gnt1, bus.gnt0};
    endtask

    // Monitor
    initial begin
        cyc_rec_t    r;
        done_rec_t   d;
        logic [1:0]  exp_done;
        logic [15:0] exp_rd [2];
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        forever begin
            @(negedge clk);
            if (cq.size() > 0) begin
                r = cq.pop_front();
                if (r.rst_prev) begin
                    exp_rd[0] = '0;
                    exp_rd[1] = '0;
                end
                chk("gnt", {30'd0, bus.gnt1, bus.gnt0}, {30'd0, r.g1, r.g0});
                chk("mem_we", {31'd0, bus.mem_we}, {31'd0, r.we});
                chk("mem_addr", {26'd0, bus.mem_addr}, {26'd0, r.addr});
                chk("mem_wd", {16'd0, bus.mem_wd}, {16'd0, r.wd});
                exp_done = 2'b00;
                if (dq.size() > 0 && dq[0].cyc == r.cyc) begin
                    d = dq.pop_front();
                    exp_done[d.port] = 1'b1;
                    if (d.rd) exp_rd[d.port] = d.data;
                end
                chk("done", {30'd0, bus.done1, bus.done0}, {30'd0, exp_done});
                chk("rdata0", {16'd0, bus.rdata0}, {16'd0, exp_rd[0]});
                chk("rdata1", {16'd0, bus.rdata1}, {16'd0, exp_rd[1]});
            end
        end
    end

    // Stimulus
    initial begin
        logic [3:0] ord;
        int         ng;
        reset = 1'b1;
        bus.req0 = 0; bus.we0 = 0; bus.addr0 = 0; bus.wd0 = 0;
        bus.req1 = 0; bus.we1 = 0; bus.addr1 = 0; bus.wd1 = 0;
        for (int i = 0; i < 64; i++) m_mem[i] = init_val(i);
        for (int p = 0; p < 2; p++) begin
            p_req[p] = 0; p_we[p] = 0; p_addr[p] = 0; p_wd[p] = 0;
            m_gc[p] = 0; m_granted[p] = 0;
        end
        m_busy = 0; m_prio = (RESET_PRIO != 0); m_rst_prev = 1; m_cc = 0;
        m_iss_we = 0; m_iss_addr = 0; m_iss_wd = 0; m_iss_port = 0;

        p_rst = 1; step(); step(); p_rst = 0; step();
        chk("reset_mem_addr", {26'd0, bus.mem_addr}, 32'd0);
        chk("reset_mem_wd", {16'd0, bus.mem_wd}, 32'd0);
`ifdef ARB_PERF_CNT_EN
        chk("reset_cnts", {grant_cnt0, grant_cnt1}, 32'd0);
`endif

        // Single port-0 read of word 2
        p_req[0] = 1; p_we[0] = 0; p_addr[0] = 6'd2;
        step();
        chk("rd2_gnt_same_cycle", {30'd0, dut_g}, 32'd1);
        p_req[0] = 0;
        step();
        chk("rd2_access_addr", {26'd0, bus.mem_addr}, 32'd2);
        step();
        chk("rd2_done_data", {15'd0, bus.done0, bus.rdata0}, {15'd0, 1'b1, 16'h2880});

        // Port-1 write then port-0 read back
        p_req[1] = 1; p_we[1] = 1; p_addr[1] = 6'd20; p_wd[1] = 16'h000A;
        step(); p_req[1] = 0; step(); step();
        p_req[0] = 1; p_we[0] = 0; p_addr[0] = 6'd20;
        step(); p_req[0] = 0; step(); step();
        chk("wr20_readback", {16'd0, bus.rdata0}, 32'h000A);

        // Contention straight after reset
        p_rst = 1; step(); p_rst = 0;
        new_req(0); new_req(1);
        ord = 0; ng = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (dut_g != 2'b00) begin
                ord = {ord[2:0], dut_g[1]};
                ng++;
            end
            for (int p = 0; p < 2; p++) if (m_granted[p]) new_req(p);
        end
        chk("contend_order", {28'd0, ord}, 32'b0101);
        chk("contend_grants", ng, 32'd4);
`ifdef ARB_PERF_CNT_EN
        chk("perf_conflict", {16'd0, conflict_cnt}, 32'd4);
        chk("perf_grants", {grant_cnt0, grant_cnt1}, {16'd2, 16'd2});
`endif
        p_req[0] = 0; p_req[1] = 0;

        // Idle, then contention again favours port 0
        for (int k = 0; k < 10; k++) step();
        p_req[0] = 1; p_we[0] = 0; p_addr[0] = 6'd3;
        p_req[1] = 1; p_we[1] = 0; p_addr[1] = 6'd4;
        step();
        chk("idle_prio_kept", {30'd0, dut_g}, 32'd1);
        p_req[0] = 0; step(); step();
        p_req[1] = 0; step(); step();

        // Reset while a write to word 5 is in its access cycle
        p_req[0] = 1; p_we[0] = 1; p_addr[0] = 6'd5; p_wd[0] = 16'hBEEF;
        step();
        p_req[0] = 0; p_rst = 1;
        step();
        chk("rst_access_we", {31'd0, bus.mem_we}, 32'd0);
        p_rst = 0;
        step(); step();
        chk("rst_mem5_kept", {16'd0, tmem[5]}, {16'd0, init_val(5)});
        p_req[0] = 1; p_we[0] = 0; p_addr[0] = 6'd5;
        p_req[1] = 1; p_we[1] = 0; p_addr[1] = 6'd6;
        step();
        chk("rst_prio", {30'd0, dut_g}, 32'd1);
        p_req[0] = 0; step(); step();
        p_req[1] = 0; step(); step();

        // Randomized traffic
        for (int k = 0; k < 500; k++) begin
            for (int p = 0; p < 2; p++)
                if (!p_req[p] && $urandom_range(2) == 0) new_req(p);
            step();
            for (int p = 0; p < 2; p++)
                if (m_granted[p]) begin
                    if ($urandom_range(1) == 1) new_req(p);
                    else p_req[p] = 0;
                end
        end
        p_req[0] = 0; p_req[1] = 0;
        for (int k = 0; k < 4; k++) step();
`ifdef ARB_PERF_CNT_EN
        chk("perf_grant0_final", {16'd0, grant_cnt0}, m_gc[0]);
        chk("perf_grant1_final", {16'd0, grant_cnt1}, m_gc[1]);
        chk("perf_conflict_final", {16'd0, conflict_cnt}, m_cc);
`endif
        @(negedge clk);
        #1;
        chk("cycle_queue_drained", cq.size(), 32'd0);
        chk("done_queue_drained", dq.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port 64x16 unified instruction/data memory between two requesters.
  - Port 0: the multi-cycle CPU control path, for fetch and load/store.
  - Port 1: the debug/program loader.
- Round-robin arbitration with a registered one-cycle access phase.
- Returns registered read data and a done pulse to the served requester.
- Sits between the requesters and the memory's addr/wd/we/rd pins.

Parameters:
- AW, 6, address width (64 words).
- DW, 16, data width.
- RESET_PRIO, 0, port that holds priority after reset (0 or 1).

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- req0  input  1  port 0 request; held with addr0/wd0/we0 stable until gnt0
- we0  input  1  port 0 write enable (1 = write, 0 = read)
- addr0  input  AW  port 0 word address
- wd0  input  DW  port 0 write data
- gnt0  output  1  port 0 request accepted this cycle (combinational)
- done0  output  1  one-cycle pulse: port 0 access completed
- rdata0  output  DW  port 0 read data, valid when done0=1
- req1, we1, addr1, wd1, gnt1, done1, rdata1: same as port 0, for port 1
- mem_addr  output  AW  memory address
- mem_wd  output  DW  memory write data
- mem_we  output  1  memory write enable
- mem_rd  input  DW  memory combinational read data

Behaviour:
- Clocking and reset: reset reset, synchronous, active-high; clock clk.
- FSM states: IDLE, ACCESS.
- IDLE:
  - winner = requesting port if only one requests.
  - If both request, winner = prio pointer.
  - gnt_x = (state==IDLE) && req_x && winner==x. At most one gnt high.
  - On the edge with gnt_x=1: latch sel=x, we_x/addr_x/wd_x into issue registers; go to ACCESS.
  - Update prio to the other port (1-x).
  - No request: stay in IDLE; prio unchanged.
- ACCESS (exactly one cycle):
  - mem_addr/mem_wd driven from the issue registers.
  - mem_we = latched we && !reset.
  - gnt0 = gnt1 = 0.
  - On the closing edge: rdata_sel <= mem_rd (reads only; rdata unchanged on writes); done_sel <= 1; go to IDLE.
- IDLE outputs: mem_we=0; mem_addr/mem_wd hold the last issue values.
- done_x:
  - Registered, high for exactly the single IDLE cycle after ACCESS.
  - The other port's done stays 0.
  - That same IDLE cycle may grant the next request, so back-to-back throughput is 1 access per 2 cycles.
- Latency: req_x high at IDLE cycle N → gnt_x in N → access in N+1 → done_x/rdata_x in N+2.
- Requester rule: after gnt_x, the requester may change fields or drop req_x in the next cycle. A req still high in the done cycle is treated as a new request.
- Simultaneous requests: strict alternation (0,1,0,1…) while both stay asserted. Neither port waits more than one access.
- Reset values:
  - state=IDLE, prio=RESET_PRIO.
  - done0=done1=0, rdata0=rdata1=0.
  - Issue registers 0, so mem_addr=0, mem_wd=0, mem_we=0.
- Reset mid-ACCESS: the access is abandoned. mem_we is forced 0 in the reset cycle, no done pulse is generated, and the next cycle is IDLE.
- rdata_x holds its value until the next completed read on that port.

Optional Feature:
- Macro ARB_PERF_CNT_EN.
- When defined, adds outputs:
  - grant_cnt0 [15:0] and grant_cnt1 [15:0]: increment on each gnt_x.
  - conflict_cnt [15:0]: increments each IDLE cycle with req0 && req1.
  - All three saturate at 16'hFFFF and reset to 0.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Single port-0 read: preload memory word 2 = 16'h2880; req0=1, we0=0, addr0=2 → gnt0 same cycle; mem_addr=2 next cycle; done0=1 with rdata0=16'h2880 two cycles after the request.
- Port-1 write then port-0 read: write addr1=20, wd1=16'h000A → mem_we=1 exactly one cycle, done1 pulse. Then port-0 read of addr 20 returns 16'h000A.
- Contention: req0 and req1 both held for 4 grants after reset (RESET_PRIO=0) → grant order 0,1,0,1; done pulses alternate; one access every 2 cycles.
- Idle: no requests for 10 cycles → mem_we=0, gnt=0, done=0, prio unchanged. Next contention is granted to port 0.
- Reset during ACCESS of a write to addr 5 → mem_we=0 in that cycle; memory word 5 unchanged (when the memory is not also reset); no done pulse; IDLE afterwards; prio=RESET_PRIO.
- With ARB_PERF_CNT_EN: 3 contended cycles plus 2 solo port-1 grants → conflict_cnt=3; grant_cnt1 counts all port-1 grants; counters clear on reset.
